ram_bank: RTL and testbench

- Parameterised successor to the team's simple RAM: one write port, one read port, single clock.
- Adds per-byte write enables, registered read with configurable latency and a valid strobe, and write-first read-during-write bypass.
- Memory clear is a sequential FSM (one address per cycle), triggered after reset or by request, instead of a reset-time loop.
- Used as the generic storage bank beneath FIFOs, register files and packet buffers.

---
 rtl/ram_pkg.sv | 32 +++
 rtl/ram_rd_pipe.sv | 34 +++
 rtl/ram_bank.sv | 127 ++++++++++++
 tb/tb_ram_bank.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the ram_bank storage block.
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Upper bound on data width accepted by merge_bytes.
  localparam int MAX_DW = 256;
  localparam int MAX_NB = MAX_DW;

  function automatic bit rd_lat_legal(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  // Replaces the lanes of old_w selected by be with the matching lanes of new_w.
  function automatic logic [MAX_DW-1:0] merge_bytes(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_NB-1:0] be,
    input int                bwidth
  );
    logic [MAX_DW-1:0] res;
    res = old_w;
    for (int i = 0; i < MAX_DW; i++) begin
      if (be[i / bwidth]) res[i] = new_w[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-result delay line: valid/data shifted RD_LAT stages, data forced to zero when not valid.
module ram_rd_pipe #(
  parameter int RD_LAT = 1,
  parameter int DWIDTH = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DWIDTH-1:0] i_data,
  output logic              o_valid,
  output logic [DWIDTH-1:0] o_data
);

  logic [RD_LAT-1:0]             r_vld;
  logic [RD_LAT-1:0][DWIDTH-1:0] r_dat;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld <= '0;
      r_dat <= '0;
    end else begin
      r_vld[0] <= i_valid;
      r_dat[0] <= i_valid ? i_data : '0;
      for (int k = 1; k < RD_LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_dat[k] <= r_dat[k-1];
      end
    end
  end

  assign o_valid = r_vld[RD_LAT-1];
  assign o_data  = r_dat[RD_LAT-1];

endmodule

// File: rtl/ram_bank.sv
// Generic 1W/1R storage bank with byte enables, pipelined read, write-first bypass
// and a sequential clear pass after reset or on request.
//
// state    | meaning
// ST_CLEAR | writing INIT_VAL to one address per cycle; user ports ignored; busy high
// ST_READY | normal operation; user writes/reads accepted; clr starts a new clear
module ram_bank
  import ram_pkg::*;
#(
  parameter int                AWIDTH   = 4,
  parameter int                DWIDTH   = 32,
  parameter int                BWIDTH   = 8,
  parameter int                RD_LAT   = 1,
  parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clr,
  input  logic                       i_we,
  input  logic [AWIDTH-1:0]          i_waddr,
  input  logic [DWIDTH-1:0]          i_wdata,
  input  logic [(DWIDTH/BWIDTH)-1:0] i_wbe,
  input  logic                       i_re,
  input  logic [AWIDTH-1:0]          i_raddr,
  output logic [DWIDTH-1:0]          o_rdata,
  output logic                       o_rvalid,
  output logic                       o_busy
);

  localparam int NB   = DWIDTH / BWIDTH;
  localparam int SIZE = 2 ** AWIDTH;

  if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
    $error("ram_bank: RD_LAT must be 1 or 2");
  end
  if ((DWIDTH % BWIDTH) != 0 || DWIDTH > MAX_DW) begin : g_bad_width
    $error("ram_bank: DWIDTH must be a multiple of BWIDTH and at most MAX_DW");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AWIDTH-1:0] r_cnt;
  logic [AWIDTH-1:0] w_cnt_nxt;
  logic [DWIDTH-1:0] r_mem [SIZE];

  logic              w_mem_we;
  logic [AWIDTH-1:0] w_mem_addr;
  logic [DWIDTH-1:0] w_mem_din;
  logic [DWIDTH-1:0] w_wr_merged;
  logic [DWIDTH-1:0] w_rd_merged;
  logic [DWIDTH-1:0] w_rd_data;
  logic              w_rd_en;
  logic              w_raw_hit;

  assign w_wr_merged = DWIDTH'(merge_bytes(MAX_DW'(r_mem[i_waddr]), MAX_DW'(i_wdata),
                                           MAX_NB'(i_wbe), BWIDTH));
  assign w_rd_merged = DWIDTH'(merge_bytes(MAX_DW'(r_mem[i_raddr]), MAX_DW'(i_wdata),
                                           MAX_NB'(i_wbe), BWIDTH));

  // Write-first: a same-edge write to the read address is visible in the read result.
  assign w_raw_hit = i_we && (i_waddr == i_raddr);
  assign w_rd_data = w_raw_hit ? w_rd_merged : r_mem[i_raddr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_cnt;
    w_mem_din   = INIT_VAL;
    w_rd_en     = 1'b0;
    o_busy      = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        o_busy    = 1'b1;
        w_mem_we  = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == AWIDTH'(SIZE - 1)) w_state_nxt = ST_READY;
      end
      ST_READY: begin
        w_rd_en = i_re;
        if (i_we) begin
          w_mem_we   = 1'b1;
          w_mem_addr = i_waddr;
          w_mem_din  = w_wr_merged;
        end
        if (i_clr) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_din;
  end

  ram_rd_pipe #(
    .RD_LAT (RD_LAT),
    .DWIDTH (DWIDTH)
  ) u_rd_pipe (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (w_rd_en),
    .i_data  (w_rd_data),
    .o_valid (o_rvalid),
    .o_data  (o_rdata)
  );

  logic [NB-1:0] w_unused_nb;
  assign w_unused_nb = i_wbe;

endmodule

// File: tb/tb_ram_bank.sv
// Bench for ram_bank: RD_LAT=1 and RD_LAT=2 instances share stimulus and are checked
// against a word-level memory model with a remaining-clear-cycles counter.
module tb_ram_bank;

  localparam logic [31:0] INIT = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst, clr, we, re;
  logic [3:0]  waddr, raddr, wbe;
  logic [31:0] wdata;
  logic [31:0] rd1, rd2;
  logic        rv1, rv2, busy1, busy2;

  always #5 clk = ~clk;

  ram_bank #(.AWIDTH(4), .DWIDTH(32), .BWIDTH(8), .RD_LAT(1), .INIT_VAL(INIT)) u_lat1 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .i_wbe(wbe), .i_re(re), .i_raddr(raddr), .o_rdata(rd1), .o_rvalid(rv1), .o_busy(busy1));

  ram_bank #(.AWIDTH(4), .DWIDTH(32), .BWIDTH(8), .RD_LAT(2), .INIT_VAL(INIT)) u_lat2 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
    .i_wbe(wbe), .i_re(re), .i_raddr(raddr), .o_rdata(rd2), .o_rvalid(rv2), .o_busy(busy2));

  logic [31:0] m_mem [16];
  int          clear_left;
  logic        e1_v, e2_v;
  logic [31:0] e1_d, e2_d;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    for (int k = 0; k < 4; k++) if (be[k]) o[k*8 +: 8] = n[k*8 +: 8];
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    chk("busy_l1", 32'(busy1), 32'(clear_left > 0));
    chk("busy_l2", 32'(busy2), 32'(clear_left > 0));
    chk("rvalid_l1", 32'(rv1), 32'(e1_v));
    chk("rdata_l1", rd1, e1_d);
    chk("rvalid_l2", 32'(rv2), 32'(e2_v));
    chk("rdata_l2", rd2, e2_d);
  endtask

  // One clock cycle: drive inputs, advance the model across the edge, check after it.
  task automatic step(input logic t_we, input logic [3:0] t_wa, input logic [31:0] t_wd,
                      input logic [3:0] t_be, input logic t_re, input logic [3:0] t_ra,
                      input logic t_clr);
    logic        ready;
    logic [31:0] rd;
    we = t_we; waddr = t_wa; wdata = t_wd; wbe = t_be; re = t_re; raddr = t_ra; clr = t_clr;
    ready = (clear_left == 0);
    rd = m_mem[t_ra];
    if (t_we && t_wa == t_ra) rd = lanes(rd, t_wd, t_be);
    e2_v = e1_v; e2_d = e1_d;
    e1_v = ready && t_re;
    e1_d = e1_v ? rd : 32'h0;
    if (ready && t_we) m_mem[t_wa] = lanes(m_mem[t_wa], t_wd, t_be);
    if (clear_left > 0) clear_left--;
    else if (t_clr) begin
      clear_left = 16;
      foreach (m_mem[i]) m_mem[i] = INIT;
    end
    @(posedge clk); #1;
    check_outs();
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a);
    step(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, a, 1'b0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    step(1'b1, a, d, be, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic apply_reset(input int hold);
    we = 0; re = 0; clr = 0; waddr = 0; raddr = 0; wdata = 0; wbe = 0;
    rst = 1'b1;
    clear_left = 16;
    e1_v = 0; e1_d = 0; e2_v = 0; e2_d = 0;
    foreach (m_mem[i]) m_mem[i] = INIT;
    #1;
    check_outs();
    repeat (hold) begin
      @(posedge clk); #1;
      check_outs();
    end
    rst = 1'b0;
  endtask

  task automatic random_step(input int clr_pct);
    step(1'($urandom_range(1)), 4'($urandom), $urandom, 4'($urandom),
         1'($urandom_range(1)), 4'($urandom), 1'($urandom_range(99) < clr_pct));
  endtask

  int count;
  logic [31:0] tbl [6];
  logic        tblv [6];

  initial begin
    rst = 0; we = 0; re = 0; clr = 0; waddr = 0; raddr = 0; wdata = 0; wbe = 0;
    e1_v = 0; e1_d = 0; e2_v = 0; e2_d = 0; clear_left = 0;
    #2;
    apply_reset(3);

    count = 0;
    while (busy1 && count < 100) begin idle(); count++; end
    chk("clear_len_after_reset", 32'(count), 32'd16);

    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      chk("init_rvalid", 32'(rv1), 32'd1);
      chk("init_rdata", rd1, INIT);
    end
    idle(); idle();

    wr(4'd3, 32'h11223344, 4'b1111);
    wr(4'd3, 32'hFFEEDDCC, 4'b0101);
    rd(4'd3);
    chk("lane_merge", rd1, 32'h11EE33CC);
    idle();
    chk("lane_merge_lat2", rd2, 32'h11EE33CC);

    wr(4'd7, 32'h0, 4'b1111);
    step(1'b1, 4'd7, 32'hDEADBEEF, 4'b0011, 1'b1, 4'd7, 1'b0);
    chk("raw_bypass", rd1, 32'h0000BEEF);
    wr(4'd6, 32'h12345678, 4'b0000);
    rd(4'd6);
    chk("wbe_zero_noop", rd1, INIT);
    idle(); idle();

    for (int a = 0; a < 4; a++) wr(4'(a), 32'(10 + a), 4'b1111);
    tblv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl  = '{32'd0, 32'd10, 32'd11, 32'd12, 32'd13, 32'd0};
    for (int i = 0; i < 6; i++) begin
      if (i < 4) rd(4'(i)); else idle();
      chk("lat2_burst_valid", 32'(rv2), 32'(tblv[i]));
      chk("lat2_burst_data", rd2, tbl[i]);
    end

    wr(4'd5, 32'h55550005, 4'b1111);
    step(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd5, 1'b1);
    chk("inflight_pre_clear", rd1, 32'h55550005);
    count = 0;
    while (busy1 && count < 100) begin random_step(0); count++; end
    chk("clear_len_on_clr", 32'(count), 32'd16);
    rd(4'd5);
    chk("post_clear_rd", rd1, INIT);
    idle(); idle();

    step(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0, 1'b1);
    repeat (7) idle();
    @(negedge clk);
    apply_reset(2);
    count = 0;
    while (busy1 && count < 100) begin idle(); count++; end
    chk("clear_len_after_midclear_rst", 32'(count), 32'd16);

    for (int i = 0; i < 600; i++) random_step(2);
    idle(); idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
